// File: rtl/otp_scheduler_pkg.sv
// Shared constants for the one-time-pad scheduler: word width, requester id width,
// FSM state encodings and the cryptor transfer function.
`ifndef KEY_SIZE
`define KEY_SIZE 32
`endif

package otp_scheduler_pkg;

  localparam int unsigned KEY_SIZE = `KEY_SIZE;
  localparam int unsigned ID_W     = 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  // Encrypt and decrypt are the same operation.
  function automatic logic [KEY_SIZE-1:0] otp_xor(input logic [KEY_SIZE-1:0] msg,
                                                  input logic [KEY_SIZE-1:0] key);
    return msg ^ key;
  endfunction

endpackage

// File: rtl/otp_scheduler_if.sv
// Key push, two request ports and the response port of the OTP scheduler, bundled.
interface otp_scheduler_if #(
  parameter int unsigned KEY_DEPTH = 8
) ();
  import otp_scheduler_pkg::*;

  localparam int unsigned CntW = $clog2(KEY_DEPTH + 1);

  logic [KEY_SIZE-1:0] key_in;
  logic                key_in_valid;
  logic                key_in_ready;
  logic [KEY_SIZE-1:0] req0_msg;
  logic                req0_valid;
  logic                req0_ready;
  logic [KEY_SIZE-1:0] req1_msg;
  logic                req1_valid;
  logic                req1_ready;
  logic [KEY_SIZE-1:0] rsp_data;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [CntW-1:0]     key_count;
  logic                busy;

  modport master (
    output key_in, key_in_valid, req0_msg, req0_valid, req1_msg, req1_valid, rsp_ready,
    input  key_in_ready, req0_ready, req1_ready, rsp_data, rsp_id, rsp_valid, key_count, busy
  );

  modport slave (
    input  key_in, key_in_valid, req0_msg, req0_valid, req1_msg, req1_valid, rsp_ready,
    output key_in_ready, req0_ready, req1_ready, rsp_data, rsp_id, rsp_valid, key_count, busy
  );

endinterface

// File: rtl/cryptor.sv
// OTP XOR datapath with a fixed clock-to-out latency of Lat register stages.
module cryptor import otp_scheduler_pkg::*; #(
  parameter int unsigned Width = KEY_SIZE,
  parameter int unsigned Lat   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] msg,
  input  logic [Width-1:0] key,
  output logic [Width-1:0] out
);

  logic [Width-1:0] pipe_q [Lat];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Lat; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= otp_xor(msg, key);
      for (int i = 1; i < Lat; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign out = pipe_q[Lat-1];

endmodule

// File: rtl/otp_key_fifo.sv
// Key word FIFO: every popped slot is zeroed so a used key never lingers in storage.
module otp_key_fifo import otp_scheduler_pkg::*; #(
  parameter int unsigned Width = KEY_SIZE,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  // A push while full is taken only when a pop frees the slot in the same cycle.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q < CntW'(Depth)) || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // When full, rd and wr pointers alias: the push write must win over the wipe.
      if (pop_ok) begin
        mem_q[rd_ptr_q] <= '0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/otp_scheduler.sv
// Shares one OTP cryptor between two requesters; each grant consumes and wipes one key word.
module otp_scheduler import otp_scheduler_pkg::*; #(
  parameter int unsigned KEY_DEPTH = 8,
  parameter int unsigned CRYPT_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  otp_scheduler_if.slave bus
);

  localparam int unsigned CntW = $clog2(KEY_DEPTH + 1);
  localparam int unsigned LatW = (CRYPT_LAT > 1) ? $clog2(CRYPT_LAT + 1) : 1;

  logic [1:0]          state_q;
  logic [LatW-1:0]     lat_q;
  logic                last_q;
  logic [ID_W-1:0]     id_q;
  logic [KEY_SIZE-1:0] msg_q, key_q, data_q;
  logic                valid_q;

  logic [CntW-1:0]     count;
  logic [KEY_SIZE-1:0] pop_key, crypt_out;
  logic                gnt0, gnt1, grant;

  // Round robin: on a tie the requester that was not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle && count != '0) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign grant = gnt0 | gnt1;

  otp_key_fifo #(
    .Width (KEY_SIZE),
    .Depth (KEY_DEPTH)
  ) u_key_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.key_in_valid),
    .push_data (bus.key_in),
    .pop       (grant),
    .pop_data  (pop_key),
    .count     (count)
  );

  cryptor #(
    .Width (KEY_SIZE),
    .Lat   (CRYPT_LAT)
  ) u_cryptor (
    .clk (clk),
    .rst (rst),
    .msg (msg_q),
    .key (key_q),
    .out (crypt_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lat_q   <= '0;
      last_q  <= 1'b1;
      id_q    <= '0;
      msg_q   <= '0;
      key_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            msg_q   <= gnt1 ? bus.req1_msg : bus.req0_msg;
            key_q   <= pop_key;
            id_q    <= ID_W'(gnt1);
            last_q  <= gnt1;
            lat_q   <= LatW'(CRYPT_LAT);
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (lat_q == '0) begin
            data_q  <= crypt_out;
            valid_q <= 1'b1;
            state_q <= StResp;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            msg_q   <= '0;
            key_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.key_in_ready = count < CntW'(KEY_DEPTH);
  assign bus.key_count    = count;
  assign bus.req0_ready   = gnt0;
  assign bus.req1_ready   = gnt1;
  assign bus.rsp_data     = data_q;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_valid    = valid_q;
  assign bus.busy         = state_q != StIdle;

endmodule

// File: tb/tb_otp_scheduler.sv
// Self-checking bench for otp_scheduler: directed tables, corner sequences, random traffic
// against a transaction-level model (key queue plus grant/response timing).
module tb_otp_scheduler;
  localparam int D  = 8;
  localparam int CL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  otp_scheduler_if #(.KEY_DEPTH(D)) bus ();

  otp_scheduler #(
    .KEY_DEPTH (D),
    .CRYPT_LAT (CL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mkeys[$];
  bit          m_pend;
  logic        m_id;
  logic        m_last;
  logic [31:0] m_data;
  int          m_cyc;
  int          m_gedge;

  // Last sampled DUT outputs
  logic        s_r0, s_r1, s_rv, s_id;
  logic [31:0] s_data;
  string       tag;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    mkeys.delete();
    m_pend  = 1'b0;
    m_id    = 1'b0;
    m_last  = 1'b1;
    m_data  = '0;
    m_cyc   = 0;
    m_gedge = 0;
  endfunction

  // bit0 = req0 granted, bit1 = req1 granted
  function automatic logic [1:0] exp_ready();
    if (m_pend || mkeys.size() == 0) return 2'b00;
    if (bus.req0_valid && bus.req1_valid) return m_last ? 2'b01 : 2'b10;
    if (bus.req1_valid) return 2'b10;
    if (bus.req0_valid) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_rv();
    return m_pend && (m_cyc >= m_gedge + CL + 1);
  endfunction

  task automatic tick();
    logic [41:0] got, exp;
    logic [1:0]  er;
    logic        erv, push_ok;
    logic [31:0] k;
    @(negedge clk);
    er  = exp_ready();
    erv = exp_rv();
    exp = {er[0], er[1], (mkeys.size() < D), 4'(mkeys.size()), m_pend, erv, m_id,
           erv ? m_data : 32'h0};
    got = {bus.req0_ready, bus.req1_ready, bus.key_in_ready, bus.key_count, bus.busy,
           bus.rsp_valid, bus.rsp_id, bus.rsp_data};
    s_r0 = bus.req0_ready; s_r1 = bus.req1_ready; s_rv = bus.rsp_valid;
    s_id = bus.rsp_id;     s_data = bus.rsp_data;
    chk(tag, 64'(got), 64'(exp));
    @(posedge clk);
    push_ok = bus.key_in_valid && ((mkeys.size() < D) || er != 2'b00);
    m_cyc++;
    if (erv && bus.rsp_ready) m_pend = 1'b0;
    if (er != 2'b00) begin
      k       = mkeys.pop_front();
      m_pend  = 1'b1;
      m_id    = er[1];
      m_last  = er[1];
      m_data  = (er[1] ? bus.req1_msg : bus.req0_msg) ^ k;
      m_gedge = m_cyc;
    end
    if (push_ok) mkeys.push_back(bus.key_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.key_in = '0; bus.key_in_valid = 1'b0;
    bus.req0_msg = '0; bus.req0_valid = 1'b0;
    bus.req1_msg = '0; bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic push_key(input logic [31:0] k);
    bus.key_in = k; bus.key_in_valid = 1'b1;
    tick();
    bus.key_in_valid = 1'b0;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    do begin tick(); n++; end while (!(s_r0 || s_r1) && n < 20);
    chk({name, "_grant_seen"}, 64'(s_r0 || s_r1), 64'd1);
  endtask

  typedef struct {
    logic        side;
    logic [31:0] key;
    logic [31:0] msg;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   lat;
  logic [31:0] hold_d;
  logic        hold_id;
  int   gids[$];
  int   alt_exp[4];

  initial begin
    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[1] = '{1'b0, 32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF};
    vecs[2] = '{1'b0, 32'h5555_5555, 32'hFFFF_FFFF, 32'hAAAA_AAAA};
    vecs[3] = '{1'b1, 32'h0F0F_0F0F, 32'h1234_5678, 32'h1D3B_5977};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h2152_4110};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    alt_exp = '{0, 1, 0, 1};

    do_reset();
    tag = "reset_state";
    tick();

    // Single requests: fixed latency, XOR result and id from the table
    tag = "vec_cycle";
    foreach (vecs[i]) begin
      push_key(vecs[i].key);
      if (vecs[i].side) begin bus.req1_msg = vecs[i].msg; bus.req1_valid = 1'b1; end
      else begin bus.req0_msg = vecs[i].msg; bus.req0_valid = 1'b1; end
      wait_grant($sformatf("vec%0d", i));
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      lat = 0;
      forever begin
        tick();
        if (s_rv || lat > 20) break;
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(CL + 1));
      chk($sformatf("vec%0d_data", i), 64'(s_data), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_id", i), 64'(s_id), 64'(vecs[i].side));
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
    end

    // Round robin with both requesters always valid
    do_reset();
    tag = "rr_cycle";
    for (int i = 0; i < 4; i++) push_key(32'h1000_0000 + 32'(i));
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
    bus.req0_msg = 32'h0000_00AA; bus.req1_msg = 32'h0000_0055;
    for (int n = 0; n < 60 && gids.size() < 4; n++) begin
      tick();
      if (s_r0) gids.push_back(0);
      if (s_r1) gids.push_back(1);
    end
    chk("rr_grant_count", 64'(gids.size()), 64'd4);
    for (int i = 0; i < 4 && i < gids.size(); i++)
      chk($sformatf("rr_order%0d", i), 64'(gids[i]), 64'(alt_exp[i]));
    repeat (8) tick();
    chk("rr_stall_no_key", 64'(bus.key_count), 64'd0);
    push_key(32'h2222_2222);
    wait_grant("rr_after_push");
    idle_inputs();
    repeat (CL + 3) tick();

    // Full FIFO: ninth push dropped, push alongside a grant accepted
    do_reset();
    tag = "full_cycle";
    push_key(32'hA000_0000);
    for (int i = 1; i < D; i++) push_key(32'hB000_0000 + 32'(i));
    chk("full_count", 64'(bus.key_count), 64'(D));
    chk("full_ready_low", 64'(bus.key_in_ready), 64'd0);
    push_key(32'hDEAD_DEAD);
    chk("ninth_push_ignored", 64'(bus.key_count), 64'(D));
    bus.key_in = 32'h9999_9999; bus.key_in_valid = 1'b1;
    bus.req0_msg = 32'h0F0F_0F0F; bus.req0_valid = 1'b1;
    wait_grant("full_pushpop");
    bus.key_in_valid = 1'b0; bus.req0_valid = 1'b0;
    chk("full_pushpop_count", 64'(bus.key_count), 64'(D));

    // Response backpressure: output stable, no grants while held
    tag = "bp_cycle";
    bus.req1_valid = 1'b1; bus.req1_msg = 32'h1111_1111;
    lat = 0;
    do begin tick(); lat++; end while (!s_rv && lat < 20);
    chk("bp_rsp_seen", 64'(s_rv), 64'd1);
    chk("bp_data", 64'(s_data), 64'hAF0F_0F0F);
    hold_d = s_data; hold_id = s_id;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i),
          64'({s_rv, s_id, s_data, s_r0, s_r1}), 64'({1'b1, hold_id, hold_d, 2'b00}));
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0; bus.req1_valid = 1'b0;
    tick();
    chk("bp_release", 64'({s_rv, s_data}), 64'd0);

    // Reset while in ISSUE
    do_reset();
    tag = "rst_cycle";
    push_key(32'h3333_3333);
    push_key(32'h4444_4444);
    bus.req0_msg = 32'h5; bus.req0_valid = 1'b1;
    wait_grant("rst_pre");
    bus.req0_valid = 1'b0;
    chk("rst_in_issue", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async", 64'({bus.rsp_valid, bus.busy, bus.key_count}), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.req0_valid = 1'b1;
    repeat (5) tick();
    chk("rst_no_grant", 64'({s_r0, s_r1, bus.key_count}), 64'd0);
    push_key(32'h7777_7777);
    wait_grant("rst_after_push");
    idle_inputs();
    repeat (CL + 3) tick();

    // Random traffic against the model
    do_reset();
    tag = "rand_cycle";
    for (int i = 0; i < 1500; i++) begin
      bus.key_in       = $urandom;
      bus.key_in_valid = ($urandom_range(0, 99) < 30);
      bus.req0_msg     = $urandom;
      bus.req0_valid   = ($urandom_range(0, 1) == 1);
      bus.req1_msg     = $urandom;
      bus.req1_valid   = ($urandom_range(0, 1) == 1);
      bus.rsp_ready    = ($urandom_range(0, 99) < 70);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otp_scheduler.md
Name: otp_scheduler

Overview:
Sequences the shared one-time-pad XOR datapath (cryptor) between two requesters and enforces single use of every key word. Key words are preloaded into an internal key FIFO. Each accepted request consumes exactly one key word and is run through the cryptor. The result is returned on a valid/ready response port tagged with the requester id, and the consumed key is wiped.

Parameters:
KEY_SIZE, `KEY_SIZE (32), data/key word width, taken from the shared constants header
KEY_DEPTH, 8, key FIFO depth in words (power of two, >=2)
CRYPT_LAT, 1, cryptor clock-to-out latency in cycles (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
key_in  in  KEY_SIZE  key word to push
key_in_valid  in  1  key push request
key_in_ready  out  1  high when key_count < KEY_DEPTH
req0_msg / req1_msg  in  KEY_SIZE  message (plaintext or ciphertext) from requester 0/1
req0_valid / req1_valid  in  1  request pending
req0_ready / req1_ready  out  1  one-cycle grant pulse; the message is taken that cycle
rsp_data  out  KEY_SIZE  cryptor result
rsp_id  out  1  requester that owns rsp_data
rsp_valid  out  1  response valid; held until rsp_ready
rsp_ready  in  1  response consumer ready
key_count  out  $clog2(KEY_DEPTH+1)  unused key words buffered
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, key_count=0, FIFO pointers=0, key/msg holding registers=0. rsp_data=0, rsp_id=0, rsp_valid=0, req*_ready=0, busy=0. Round-robin pointer last_grant=1, so req0 wins the first tie.
- Key FIFO:
  - Push on key_in_valid && key_in_ready.
  - Pop only on a grant.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal even when full, since ready is evaluated before the pop.
  - Pointers wrap modulo KEY_DEPTH. A vacated slot is written to 0 on pop.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE:
    - If key_count>0 and any reqX_valid, grant.
    - If both requesters are valid, grant the one != last_grant. Otherwise grant the single valid one.
    - On grant: assert reqX_ready for that cycle only. Latch reqX_msg and the popped key into holding registers. Latch the id, update last_grant, move to ISSUE.
    - If key_count==0, no grant is made; requests stall with no error and no key reuse.
  - ISSUE:
    - Holding registers drive the cryptor msg/key inputs.
    - Stay for exactly CRYPT_LAT+1 cycles (down-counter).
    - On the last cycle, capture cryptor out into rsp_data, set rsp_valid=1, move to RESP.
  - RESP:
    - Hold rsp_data/rsp_id/rsp_valid stable while rsp_ready=0.
    - On rsp_valid && rsp_ready: clear rsp_valid, rsp_data, and the key/msg holding registers to 0; return to IDLE.
- Latency: request granted at edge N gives rsp_valid=1 after edge N+CRYPT_LAT+1. Minimum spacing between grants is CRYPT_LAT+3 cycles.
- A new grant is never made in the RESP exit cycle. Grants occur only from IDLE.
- Requester ready is never asserted while key_count==0 or busy=1.
- Arithmetic: the cryptor result is the bitwise XOR of msg and key, width KEY_SIZE, no carry. Encrypt and decrypt are the same operation.
- Reset mid-operation: in-flight request dropped, no response emitted, all buffered keys discarded. Software must reload keys.
- A key word is used at most once; after use it is not recoverable from any register.

Decomposition:
- Shared constants header: KEY_SIZE.
- New shared package/header: FSM state encodings (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) and the requester id width.
- Sub-modules:
  - Instantiate the existing cryptor unchanged as the datapath.
  - otp_key_fifo is the one natural new sub-module: synchronous FIFO with wipe-on-pop and count output.

Test Plan:
- Push key FFFF_FFFF; req0_msg=0000_0000 valid -> req0_ready pulse at edge N, rsp_valid after N+2 (CRYPT_LAT=1), rsp_data=FFFF_FFFF, rsp_id=0, key_count 1->0.
- Push keys 5555_5555, 5555_5555. req0 sends AAAA_AAAA, then FFFF_FFFF -> responses FFFF_FFFF then AAAA_AAAA (round-trip decrypt); key_count ends at 0.
- Push 4 keys; hold req0 and req1 valid continuously -> grants alternate 0,1,0,1; rsp_id matches; the fifth request stalls with ready=0 until a key is pushed.
- Push KEY_DEPTH keys -> key_in_ready=0, and a ninth push is ignored. A push coinciding with a grant when full is accepted and key_count stays 8.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_id stable, no new req*_ready. Release -> rsp_valid=0 next cycle and rsp_data=0.
- Assert rst during ISSUE -> immediately rsp_valid=0, busy=0, key_count=0. After release a request gets no grant until a key is pushed.
